// File: rtl/tmr_sched.sv
// ---------------------------------------------------------------------------
// tmr_sched - multi-channel timer scheduler
//
// One shared 32-bit decrement datapath is time-multiplexed over NCH channel
// counters. A free-running prescaler produces a one-clock tick every PRESCALE
// clocks; each tick launches a scan that services one channel per cycle
// (tick in cycle T services channel k in cycle T+1+k).
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   en        bus select
//   wr        bus write strobe (qualified by en)
//   addr      word address {ch[1:0], reg[1:0]}
//                reg 0 ctrl    {28'b0, oneshot, run, ien, alarm}  R/W
//                reg 1 divisor                                    R/W
//                reg 2 counter                                    RO
//                reg 3 status  {alarm[NCH-1:0]} zero-extended      RO
//   data_in   bus write data
//   data_out  bus read data, combinational from addr
//   wt        bus wait, always 0
//   irq       OR of irq_vec
//   irq_vec   per-channel ien & alarm
//
// Optional feature macro: TMR_SCHED_ONESHOT_EN
//   defined   : oneshot bit implemented, expiry of a oneshot channel clears run
//   undefined : oneshot bit reads 0, writes to it are ignored, channels always
//               auto-reload and keep running
// ---------------------------------------------------------------------------
module tmr_sched #(
  parameter int NCH      = 4,
  parameter int PRESCALE = 50
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           wr,
  input  logic [3:0]     addr,
  input  logic [31:0]    data_in,
  output logic [31:0]    data_out,
  output logic           wt,
  output logic           irq,
  output logic [NCH-1:0] irq_vec
);

  localparam int PW = $clog2(PRESCALE + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [PW-1:0]  presc_q, presc_d;
  logic           tick_q, tick_d;
  logic [0:0]     state_q, state_d;
  logic [1:0]     idx_q, idx_d;

  logic [31:0]    div_q [NCH];
  logic [31:0]    div_d [NCH];
  logic [31:0]    cnt_q [NCH];
  logic [31:0]    cnt_d [NCH];
  logic [NCH-1:0] run_q, run_d;
  logic [NCH-1:0] ien_q, ien_d;
  logic [NCH-1:0] alarm_q, alarm_d;
  logic [NCH-1:0] oneshot_q, oneshot_d;

  logic [NCH-1:0] svc_vec;
  logic [NCH-1:0] exp_vec;
  logic [NCH-1:0] wsel_vec;

  logic           bus_wr;
  logic [1:0]     bus_ch;
  logic [1:0]     bus_reg;

  assign bus_wr  = en & wr;
  assign bus_ch  = addr[3:2];
  assign bus_reg = addr[1:0];
  assign wt      = 1'b0;

  // Prescaler counts PRESCALE..1; the reload cycle raises tick for one clock.
  always_comb begin
    tick_d  = 1'b0;
    presc_d = presc_q - PW'(1);
    if (presc_q == PW'(1)) begin
      presc_d = PW'(PRESCALE);
      tick_d  = 1'b1;
    end
  end

  // Scan sequencer: a tick starts a sweep of channels 0..NCH-1.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_q) begin
          state_d = ST_SCAN;
          idx_d   = 2'd0;
        end
      end
      ST_SCAN: begin
        if (idx_q == 2'(NCH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-channel qualifiers: serviced this cycle, expiring, targeted by bus.
  always_comb begin
    svc_vec  = '0;
    exp_vec  = '0;
    wsel_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      svc_vec[i]  = (state_q == ST_SCAN) && (idx_q == 2'(i)) && run_q[i];
      exp_vec[i]  = svc_vec[i] && (cnt_q[i] <= 32'd1);
      wsel_vec[i] = bus_wr && (bus_ch == 2'(i));
    end
  end

  // Channel next state. A divisor write replaces that channel's service for
  // the cycle; a ctrl write merges with a concurrent expiry so the alarm is
  // never lost and a oneshot expiry still stops the channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      div_d[i]     = div_q[i];
      cnt_d[i]     = cnt_q[i];
      run_d[i]     = run_q[i];
      ien_d[i]     = ien_q[i];
      alarm_d[i]   = alarm_q[i];
      oneshot_d[i] = oneshot_q[i];

      if (wsel_vec[i] && (bus_reg == 2'd1)) begin
        div_d[i] = data_in;
        cnt_d[i] = data_in;
      end else begin
        if (exp_vec[i]) begin
          cnt_d[i]   = div_q[i];
          alarm_d[i] = 1'b1;
          if (oneshot_q[i]) begin
            run_d[i] = 1'b0;
          end
        end else if (svc_vec[i]) begin
          cnt_d[i] = cnt_q[i] - 32'd1;
        end

        if (wsel_vec[i] && (bus_reg == 2'd0)) begin
          alarm_d[i] = data_in[0] | exp_vec[i];
          ien_d[i]   = data_in[1];
          run_d[i]   = data_in[2] & ~(exp_vec[i] & oneshot_q[i]);
`ifdef TMR_SCHED_ONESHOT_EN
          oneshot_d[i] = data_in[3];
`else
          oneshot_d[i] = 1'b0;
`endif
        end
      end
    end
  end

  // State registers; reset returns every channel to a free-running,
  // interrupt-disabled, full-count state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= PW'(PRESCALE);
      tick_q    <= 1'b0;
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      run_q     <= '1;
      ien_q     <= '0;
      alarm_q   <= '0;
      oneshot_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= 32'hFFFF_FFFF;
        cnt_q[i] <= 32'hFFFF_FFFF;
      end
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_q     <= run_d;
      ien_q     <= ien_d;
      alarm_q   <= alarm_d;
      oneshot_q <= oneshot_d;
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Read mux; channel windows beyond NCH read as zero.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus_ch == 2'(i)) begin
        case (bus_reg)
          2'd0:    data_out = {28'b0, oneshot_q[i], run_q[i], ien_q[i], alarm_q[i]};
          2'd1:    data_out = div_q[i];
          2'd2:    data_out = cnt_q[i];
          default: data_out = 32'(alarm_q);
        endcase
      end
    end
  end

  assign irq_vec = ien_q & alarm_q;
  assign irq     = |irq_vec;

  // A tick arriving mid-scan would skip channels; PRESCALE must leave room.
  tick_in_scan_a: assert property (@(posedge clk) disable iff (!reset)
    !(tick_q && (state_q == ST_SCAN)));

endmodule

// File: tb/tb_tmr_sched.sv
// ---------------------------------------------------------------------------
// tb_tmr_sched - directed testbench for tmr_sched (NCH=4, PRESCALE=8).
// Cycle n is the interval after the n-th rising edge following reset release;
// ticks occur in cycles 8, 16, 24, ... and channel k of the tick in cycle T is
// updated as seen from cycle T+2+k.
// ---------------------------------------------------------------------------
module tb_tmr_sched;

  localparam int NCH      = 4;
  localparam int PRESCALE = 8;

  logic           clk;
  logic           reset;
  logic           en;
  logic           wr;
  logic [3:0]     addr;
  logic [31:0]    data_in;
  logic [31:0]    data_out;
  logic           wt;
  logic           irq;
  logic [NCH-1:0] irq_vec;

  int n_checks;
  int n_fail;
  int cyc;

  typedef struct {
    string       name;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  logic [31:0] exp_ctrl3_armed;
  logic [31:0] exp_ctrl3_fired;
  logic [31:0] exp_cnt3_c173;

  tmr_sched #(.NCH(NCH), .PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .wt       (wt),
    .irq      (irq),
    .irq_vec  (irq_vec)
  );

  // 100-time-unit clock leaves room for several reads inside one cycle
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Advance one cycle and land just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gotoCycle(input int n);
    while (cyc < n) step();
  endtask

  // Drive a bus access; writes take one cycle, reads just settle the mux
  task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [31:0] d);
    en      = w;
    wr      = w;
    addr    = a;
    data_in = d;
    if (w) begin
      step();
      en = 1'b0;
      wr = 1'b0;
    end else begin
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic readCheck(input string name, input logic [3:0] a, input logic [31:0] exp);
    applyStimulus(1'b0, a, 32'd0);
    checkOutput(name, data_out, exp);
  endtask

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b0;
    en       = 1'b0;
    wr       = 1'b0;
    addr     = 4'd0;
    data_in  = 32'd0;

`ifdef TMR_SCHED_ONESHOT_EN
    exp_ctrl3_armed = 32'hE;
    exp_ctrl3_fired = 32'hB;
    exp_cnt3_c173   = 32'd2;
`else
    exp_ctrl3_armed = 32'h6;
    exp_ctrl3_fired = 32'h7;
    exp_cnt3_c173   = 32'd1;
`endif

    // Reset-state table: every register window, then ignored writes
    for (int i = 0; i < 16; i++) begin
      vecs[i].name = $sformatf("reset_rd_addr%0d", i);
      vecs[i].wr   = 1'b0;
      vecs[i].addr = 4'(i);
      vecs[i].data = 32'd0;
      case (i % 4)
        0:       vecs[i].exp = 32'h4;
        1, 2:    vecs[i].exp = 32'hFFFF_FFFF;
        default: vecs[i].exp = 32'h0;
      endcase
    end
    vecs[16] = '{"wr_cnt0_ignored",  1'b1, 4'b0010, 32'h1234_5678, 32'h0};
    vecs[17] = '{"wr_stat0_ignored", 1'b1, 4'b0011, 32'h0000_FFFF, 32'h0};
    vecs[18] = '{"cnt0_after_wr",    1'b0, 4'b0010, 32'h0,         32'hFFFF_FFFF};
    vecs[19] = '{"stat0_after_wr",   1'b0, 4'b0011, 32'h0,         32'h0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;

    checkOutput("reset_irq", {31'b0, irq}, 32'd0);
    checkOutput("reset_irq_vec", 32'(irq_vec), 32'd0);
    checkOutput("wt_tied", {31'b0, wt}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) begin
        applyStimulus(1'b1, vecs[i].addr, vecs[i].data);
      end else begin
        applyStimulus(1'b0, vecs[i].addr, 32'd0);
        checkOutput(vecs[i].name, data_out, vecs[i].exp);
      end
    end

    // First tick lands in cycle 8: ch0 changes at 10, ch3 at 13
    gotoCycle(9);
    readCheck("first_tick_cnt0_pre", 4'b0010, 32'hFFFF_FFFF);
    step();
    readCheck("first_tick_cnt0_post", 4'b0010, 32'hFFFF_FFFE);
    gotoCycle(12);
    readCheck("first_tick_cnt3_pre", 4'b1110, 32'hFFFF_FFFF);
    step();
    readCheck("first_tick_cnt3_post", 4'b1110, 32'hFFFF_FFFE);

    // ch1 divisor 3, run+ien: expiries serviced in cycles 34, 58, 82, ...
    gotoCycle(14);
    applyStimulus(1'b1, 4'b0101, 32'd3);
    applyStimulus(1'b1, 4'b0100, 32'h6);
    readCheck("ch1_cnt_loaded", 4'b0110, 32'd3);
    gotoCycle(27);
    readCheck("ch1_cnt_after2", 4'b0110, 32'd1);
    gotoCycle(34);
    checkOutput("ch1_irq_before", {31'b0, irq}, 32'd0);
    step();
    checkOutput("ch1_irq_set", {31'b0, irq}, 32'd1);
    checkOutput("ch1_irq_vec", 32'(irq_vec), 32'h2);
    readCheck("ch1_status", 4'b0111, 32'h2);
    readCheck("ch0_status_win", 4'b0011, 32'h2);
    readCheck("ch1_cnt_reload", 4'b0110, 32'd3);

    // Clearing alarm drops irq next cycle; alarm returns 3 ticks later
    gotoCycle(36);
    checkOutput("ch1_irq_held", {31'b0, irq}, 32'd1);
    applyStimulus(1'b1, 4'b0100, 32'h6);
    checkOutput("ch1_irq_cleared", {31'b0, irq}, 32'd0);
    gotoCycle(58);
    checkOutput("ch1_irq_pre_rearm", {31'b0, irq}, 32'd0);
    step();
    checkOutput("ch1_irq_rearm", {31'b0, irq}, 32'd1);

    // Keep alarm set but disable the interrupt
    gotoCycle(60);
    applyStimulus(1'b1, 4'b0100, 32'h5);
    checkOutput("ch1_irq_masked", {31'b0, irq}, 32'd0);
    readCheck("ch1_ctrl_masked", 4'b0100, 32'h5);
    readCheck("ch1_status_masked", 4'b0111, 32'h2);

    // Divisor write colliding with ch0 service (tick 64 services ch0 in 65)
    gotoCycle(65);
    applyStimulus(1'b1, 4'b0001, 32'd5);
    readCheck("collide_cnt0", 4'b0010, 32'd5);
    readCheck("collide_div0", 4'b0001, 32'd5);
    gotoCycle(67);
    readCheck("ch2_cnt_pre", 4'b1010, 32'hFFFF_FFF8);
    step();
    readCheck("ch2_cnt_serviced", 4'b1010, 32'hFFFF_FFF7);
    gotoCycle(74);
    readCheck("ch0_cnt_next_tick", 4'b0010, 32'd4);

    // Ctrl write clearing alarm in the cycle ch1 expires: alarm still wins
    gotoCycle(76);
    applyStimulus(1'b1, 4'b0100, 32'h4);
    readCheck("ch1_ctrl_cleared", 4'b0100, 32'h4);
    gotoCycle(82);
    applyStimulus(1'b1, 4'b0100, 32'h6);
    readCheck("ctrl_collide_ctrl", 4'b0100, 32'h7);
    checkOutput("ctrl_collide_irq", {31'b0, irq}, 32'd1);
    readCheck("ctrl_collide_cnt", 4'b0110, 32'd3);

    // ch3 oneshot: divisor 2, ctrl 0xE; expiry serviced in cycle 100
    gotoCycle(84);
    applyStimulus(1'b1, 4'b1101, 32'd2);
    applyStimulus(1'b1, 4'b1100, 32'hE);
    readCheck("ch3_ctrl_armed", 4'b1100, exp_ctrl3_armed);
    gotoCycle(100);
    readCheck("ch3_cnt_pre", 4'b1110, 32'd1);
    checkOutput("ch3_irq_vec_pre", 32'(irq_vec), 32'h2);
    step();
    checkOutput("ch3_irq_vec_fired", 32'(irq_vec), 32'hA);
    readCheck("ch3_ctrl_fired", 4'b1100, exp_ctrl3_fired);
    readCheck("ch3_cnt_reload", 4'b1110, 32'd2);
    gotoCycle(173);
    readCheck("ch3_cnt_c173", 4'b1110, exp_cnt3_c173);
    gotoCycle(181);
    readCheck("ch3_cnt_c181", 4'b1110, 32'd2);
    readCheck("ch3_ctrl_c181", 4'b1100, exp_ctrl3_fired);

    // Divisor 0 on ch2 expires on the first service
    gotoCycle(182);
    applyStimulus(1'b1, 4'b1001, 32'd0);
    readCheck("div0_cnt_loaded", 4'b1010, 32'd0);
    gotoCycle(187);
    readCheck("div0_ctrl_pre", 4'b1000, 32'h4);
    step();
    readCheck("div0_ctrl_fired", 4'b1000, 32'h5);
    readCheck("div0_cnt_reload", 4'b1010, 32'd0);

    // Reset in the middle of the scan for tick 192
    gotoCycle(194);
    reset = 1'b0;
    #1;
    checkOutput("midscan_irq", {31'b0, irq}, 32'd0);
    checkOutput("midscan_irq_vec", 32'(irq_vec), 32'd0);
    readCheck("midscan_ctrl1", 4'b0100, 32'h4);
    readCheck("midscan_div1", 4'b0101, 32'hFFFF_FFFF);
    readCheck("midscan_cnt2", 4'b1010, 32'hFFFF_FFFF);
    readCheck("midscan_ctrl3", 4'b1100, 32'h4);
    readCheck("midscan_status", 4'b0011, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
